// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - issue controller for a fixed-latency wave-pipelined datapath
// Tokens track wavefronts; credits reserve FIFO space at issue so a capture never overflows.
module pipe_issue_ctrl #(
  parameter int IN_W  = 27,
  parameter int OUT_W = 6,
  parameter int LAT   = 9,
  parameter int II    = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_data,
  output logic [IN_W-1:0]  o_dp_in,
  input  logic [OUT_W-1:0] i_dp_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_busy
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW  = (II > 1) ? $clog2(II) : 1;

  localparam logic [CW1-1:0] DEPTH_C  = CW1'(DEPTH);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(II - 1);
  localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);

  logic [IN_W-1:0]  r_dp_in;
  logic [LAT-1:0]   r_tok_sr;
  logic [CW-1:0]    r_inflight;
  logic [CW-1:0]    r_occ;
  logic [GW-1:0]    r_gap;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OUT_W-1:0] r_mem [DEPTH];

  logic           w_accept;
  logic           w_capture;
  logic           w_pop;
  logic [LAT-1:0] w_tok_nxt;
  logic [CW-1:0]  w_inflight_nxt;
  logic [CW-1:0]  w_occ_nxt;
  logic [CW1-1:0] w_credit;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // Ready is a pure function of registered state; a same-edge pop cannot free a credit early.
  assign w_credit    = DEPTH_C - {1'b0, r_inflight} - {1'b0, r_occ};
  assign o_in_ready  = (w_credit != '0) && (r_gap == '0);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_capture   = r_tok_sr[LAT-1];
  assign o_out_valid = (r_occ != '0);
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_busy      = (r_inflight != '0) || (r_occ != '0);
  assign o_dp_in     = r_dp_in;

  always_comb begin
    w_tok_nxt    = r_tok_sr << 1;
    w_tok_nxt[0] = w_accept;

    w_inflight_nxt = r_inflight;
    case ({w_accept, w_capture})
      2'b10:   w_inflight_nxt = r_inflight + CW'(1);
      2'b01:   w_inflight_nxt = r_inflight - CW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase

    w_occ_nxt = r_occ;
    case ({w_capture, w_pop})
      2'b10:   w_occ_nxt = r_occ + CW'(1);
      2'b01:   w_occ_nxt = r_occ - CW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_in    <= '0;
      r_tok_sr   <= '0;
      r_inflight <= '0;
      r_occ      <= '0;
      r_gap      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_tok_sr   <= w_tok_nxt;
      r_inflight <= w_inflight_nxt;
      r_occ      <= w_occ_nxt;
      if (w_accept) begin
        r_dp_in <= i_in_data;
        r_gap   <= GAP_LOAD;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
      if (w_capture) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_capture) r_mem[r_wr_ptr] <= i_dp_out;
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - directed self-checking bench for pipe_issue_ctrl
// Instance a runs II=1, instance b runs II=3; both share clock and reset.
module tb_pipe_issue_ctrl;
  localparam int IN_W  = 27;
  localparam int OUT_W = 6;
  localparam int LAT   = 9;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [IN_W-1:0]  a_in_data, a_dp_in;
  logic [OUT_W-1:0] a_dp_out, a_out_data;
  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [IN_W-1:0]  b_in_data, b_dp_in;
  logic [OUT_W-1:0] b_dp_out, b_out_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int cyc      = 0;
  int acc_cyc[$];
  logic [OUT_W-1:0] exp_q[$];

  function automatic logic [OUT_W-1:0] dp_fn(input logic [IN_W-1:0] x);
    logic [5:0] s;
    s = x[5:0] + x[11:6] + x[17:12] + x[23:18] + {3'b000, x[26:24]};
    return s;
  endfunction

  function automatic logic [IN_W-1:0] vec(input int i);
    return IN_W'((32'h0213_5A71 * (i + 1)) ^ 32'h0155_AA33);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  pipe_issue_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT), .II(1), .DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
    .o_dp_in(a_dp_in), .i_dp_out(a_dp_out),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
    .o_busy(a_busy)
  );

  pipe_issue_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT), .II(3), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
    .o_dp_in(b_dp_in), .i_dp_out(b_dp_out),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
    .o_busy(b_busy)
  );

  // Datapath stand-in: result of dp_in is valid LAT edges after it was loaded.
  logic [IN_W-1:0] a_dly [1:LAT-1];
  always @(posedge clk) begin
    a_dly[1] <= a_dp_in;
    for (int k = 2; k < LAT; k++) a_dly[k] <= a_dly[k-1];
  end
  assign a_dp_out = dp_fn(a_dly[LAT-1]);
  assign b_dp_out = dp_fn(b_dp_in);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (a_in_valid && a_in_ready) exp_q.push_back(dp_fn(a_in_data));
      if (a_out_valid && a_out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) chk("pop_without_issue", 32'(a_out_data), 32'hFFFF_FFFF);
        else                   chk("pop_order_data", 32'(a_out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int n, input int base, input int budget, output int sent);
    logic acc;
    sent = 0;
    for (int c = 0; c < budget && sent < n; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = vec(base + sent);
      @(negedge clk);
      acc = a_in_ready;
      tick();
      if (acc) begin
        sent++;
        acc_cyc.push_back(cyc);
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    for (int c = 0; c < budget && n_pops < target; c++) tick();
    chk(tag, 32'(n_pops), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    int sent, base_pops, min_gap;
    logic acc;
    logic rdy_after[24];
    int b_acc[$];

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_in_ready", 32'(a_in_ready), 32'd1);
    chk("reset_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_dp_in", 32'(a_dp_in), 32'd0);

    a_in_valid = 1'b1;
    a_in_data  = 27'h5A5A5A;
    tick();
    a_in_valid = 1'b0;
    chk("single_dp_in", 32'(a_dp_in), 32'h005A_5A5A);
    chk("single_busy_inflight", 32'(a_busy), 32'd1);
    repeat (8) tick();
    chk("single_not_early", 32'(a_out_valid), 32'd0);
    tick();
    chk("single_out_valid", 32'(a_out_valid), 32'd1);
    chk("single_out_data", 32'(a_out_data), 32'h3E);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("single_out_valid_after_pop", 32'(a_out_valid), 32'd0);
    chk("single_busy_after_pop", 32'(a_busy), 32'd0);

    base_pops = n_pops;
    a_out_ready = 1'b1;
    acc_cyc.delete();
    send_a(20, 0, 400, sent);
    chk("stream_accepted", 32'(sent), 32'd20);
    min_gap = 1000;
    for (int i = 4; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-4] < min_gap) min_gap = acc_cyc[i] - acc_cyc[i-4];
    chk("stream_4_per_10_window", 32'(min_gap >= 10), 32'd1);
    if (acc_cyc.size() == 20)
      chk("stream_credit_stall", 32'(acc_cyc[19] - acc_cyc[0] > 19), 32'd1);
    wait_pops("stream_all_results", base_pops + 20, 100);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    base_pops = n_pops;
    a_out_ready = 1'b0;
    send_a(8, 100, 30, sent);
    chk("bp_accept_count", 32'(sent), 32'd4);
    chk("bp_out_valid", 32'(a_out_valid), 32'd1);
    chk("bp_in_ready_full", 32'(a_in_ready), 32'd0);
    chk("bp_busy", 32'(a_busy), 32'd1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("bp_single_pop", 32'(n_pops - base_pops), 32'd1);
    chk("bp_in_ready_after_pop", 32'(a_in_ready), 32'd1);
    a_out_ready = 1'b1;
    send_a(4, 104, 200, sent);
    chk("bp_rest_accepted", 32'(sent), 32'd4);
    wait_pops("bp_all_results", base_pops + 8, 100);

    for (int j = 0; j < 24; j++) begin
      b_in_valid = 1'b1;
      b_in_data  = vec(300 + j);
      @(negedge clk);
      acc = b_in_ready;
      tick();
      rdy_after[j] = b_in_ready;
      if (acc) b_acc.push_back(j);
    end
    b_in_valid = 1'b0;
    chk("gap_accept_count", 32'(b_acc.size() >= 5), 32'd1);
    if (b_acc.size() >= 5) begin
      chk("gap_first_edge", 32'(b_acc[0]), 32'd0);
      for (int k = 1; k < 5; k++) chk("gap_step", 32'(b_acc[k] - b_acc[k-1]), 32'd3);
    end
    chk("gap_ready_low_1", 32'(rdy_after[0]), 32'd0);
    chk("gap_ready_low_2", 32'(rdy_after[1]), 32'd0);
    chk("gap_ready_high_3", 32'(rdy_after[2]), 32'd1);

    a_out_ready = 1'b0;
    send_a(2, 200, 20, sent);
    repeat (12) tick();
    send_a(2, 202, 20, sent);
    tick();
    chk("mid_busy_before", 32'(a_busy), 32'd1);
    chk("mid_out_valid_before", 32'(a_out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_out_valid_async", 32'(a_out_valid), 32'd0);
    chk("mid_busy_async", 32'(a_busy), 32'd0);
    chk("mid_dp_in_async", 32'(a_dp_in), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mid_no_capture", 32'(a_out_valid), 32'd0);
    end
    chk("mid_in_ready", 32'(a_in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
